// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Optional link (call/return) support is enabled with INST_FETCH_LINK_EN.
package fetch_pkg;

  localparam int         PC_W_DEF       = 8;
  localparam logic [7:0] START_ADDR_DEF = 8'h00;

  // Control FSM of the fetch stage
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // Which source feeds the PC register on the next edge
  typedef enum logic [2:0] {
    HOLD    = 3'd0,
    SEQ     = 3'd1,
    JUMP    = 3'd2,
    BRANCH  = 3'd3,
    CALL    = 3'd4,
    RET     = 3'd5,
    RESTART = 3'd6
  } pc_sel_t;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux with wrapping sequential and relative-branch adders.
// Call/return sources exist only when INST_FETCH_LINK_EN is defined.
module next_pc_sel
  import fetch_pkg::*;
#(
  parameter int              PC_W       = PC_W_DEF,
  parameter logic [PC_W-1:0] START_ADDR = PC_W'(START_ADDR_DEF)
) (
  input  logic            running,
  input  logic            start,
  input  logic            halt,
  input  logic            jumpEn,
  input  logic            branchEn,
`ifdef INST_FETCH_LINK_EN
  input  logic            callEn,
  input  logic            retEn,
  input  logic [PC_W-1:0] linkAddr,
  output logic [PC_W-1:0] pcPlusOne,
`endif
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] jumpTarget,
  input  logic [PC_W-1:0] branchOffset,
  output logic [PC_W-1:0] pcNext,
  output pc_sel_t         sel
);

  logic [PC_W-1:0] seqPc;
  logic [PC_W-1:0] branchPc;

  // Both adders are PC_W wide, so overflow simply wraps; adding the raw
  // offset bits is the same as adding its sign extension modulo 2^PC_W.
  assign seqPc    = pc + PC_W'(1);
  assign branchPc = pc + branchOffset;

`ifdef INST_FETCH_LINK_EN
  assign pcPlusOne = seqPc;
`endif

  // Priority decode: start beats everything; other controls only act in RUN
  always_comb begin
    sel = HOLD;
    if (start) begin
      sel = RESTART;
    end else if (running) begin
      if (halt)          sel = HOLD;
      else if (jumpEn)   sel = JUMP;
`ifdef INST_FETCH_LINK_EN
      else if (callEn)   sel = CALL;
      else if (retEn)    sel = RET;
`endif
      else if (branchEn) sel = BRANCH;
      else               sel = SEQ;
    end
  end

  // Steer the selected source onto the next PC
  always_comb begin
    pcNext = pc;
    case (sel)
      RESTART: pcNext = START_ADDR;
      SEQ:     pcNext = seqPc;
      JUMP:    pcNext = jumpTarget;
      BRANCH:  pcNext = branchPc;
`ifdef INST_FETCH_LINK_EN
      CALL:    pcNext = jumpTarget;
      RET:     pcNext = linkAddr;
`endif
      default: pcNext = pc;
    endcase
  end

endmodule

// File: rtl/inst_fetch.sv
// Program counter / instruction fetch stage with run/halt control FSM and
// a saturating retired-instruction counter.
// Define INST_FETCH_LINK_EN to add call_en/ret_en and a one-level link register.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int              PC_W       = PC_W_DEF,
  parameter logic [PC_W-1:0] START_ADDR = PC_W'(START_ADDR_DEF),
  parameter int              CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             init,
  input  logic             start,
  input  logic             halt,
  input  logic             jump_en,
  input  logic             branch_en,
`ifdef INST_FETCH_LINK_EN
  input  logic             call_en,
  input  logic             ret_en,
`endif
  input  logic [PC_W-1:0]  JumpTarget,
  input  logic [PC_W-1:0]  BranchOffset,
  output logic [PC_W-1:0]  InstAddress,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] FetchCount
);

  fetch_state_t    stateReg, stateNext;
  logic [PC_W-1:0] pcReg;
  logic [PC_W-1:0] pcNext;
  logic [CNT_W-1:0] countReg;
  pc_sel_t         pcSel;
  logic            isRun;

  assign isRun = (stateReg == RUN);

`ifdef INST_FETCH_LINK_EN
  logic [PC_W-1:0] linkReg;
  logic [PC_W-1:0] pcPlusOne;
`endif

  next_pc_sel #(
    .PC_W       (PC_W),
    .START_ADDR (START_ADDR)
  ) u_next_pc_sel (
    .running      (isRun),
    .start        (start),
    .halt         (halt),
    .jumpEn       (jump_en),
    .branchEn     (branch_en),
`ifdef INST_FETCH_LINK_EN
    .callEn       (call_en),
    .retEn        (ret_en),
    .linkAddr     (linkReg),
    .pcPlusOne    (pcPlusOne),
`endif
    .pc           (pcReg),
    .jumpTarget   (JumpTarget),
    .branchOffset (BranchOffset),
    .pcNext       (pcNext),
    .sel          (pcSel)
  );

  // FSM state register
  always_ff @(posedge CLK) begin
    if (init) stateReg <= IDLE;
    else      stateReg <= stateNext;
  end

  // FSM transitions: start (re)enters RUN from any state, halt leaves RUN
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (start) stateNext = RUN;
      RUN: begin
        if (start)     stateNext = RUN;
        else if (halt) stateNext = HALTED;
      end
      HALTED:  if (start) stateNext = RUN;
      default: stateNext = IDLE;
    endcase
  end

  // PC register; the mux already holds it outside RUN
  always_ff @(posedge CLK) begin
    if (init) pcReg <= '0;
    else      pcReg <= pcNext;
  end

  // Retired count: cleared on (re)start, one per RUN cycle, sticks at all-ones
  always_ff @(posedge CLK) begin
    if (init)                             countReg <= '0;
    else if (pcSel == RESTART)            countReg <= '0;
    else if (isRun && (countReg != '1))   countReg <= countReg + CNT_W'(1);
  end

`ifdef INST_FETCH_LINK_EN
  // Single-level link: every call overwrites the return address
  always_ff @(posedge CLK) begin
    if (init)               linkReg <= '0;
    else if (pcSel == CALL) linkReg <= pcPlusOne;
  end
`endif

  assign InstAddress = pcReg;
  assign running     = isRun;
  assign done        = (stateReg == HALTED);
  assign FetchCount  = countReg;

endmodule

// File: tb/tb_inst_fetch.sv
// Table-driven bench for inst_fetch; each row is one clock of stimulus plus
// the outputs expected right after that edge. Link rows need INST_FETCH_LINK_EN.
module tb_inst_fetch;

  localparam int CNT_W = 4;  // small so saturation is reachable quickly

  logic             CLK;
  logic             init, start, halt, jump_en, branch_en;
  logic             call_en, ret_en;
  logic [7:0]       JumpTarget, BranchOffset;
  logic [7:0]       InstAddress;
  logic             running, done;
  logic [CNT_W-1:0] FetchCount;

  inst_fetch #(
    .PC_W       (8),
    .START_ADDR (8'h00),
    .CNT_W      (CNT_W)
  ) dut (
    .CLK          (CLK),
    .init         (init),
    .start        (start),
    .halt         (halt),
    .jump_en      (jump_en),
    .branch_en    (branch_en),
`ifdef INST_FETCH_LINK_EN
    .call_en      (call_en),
    .ret_en       (ret_en),
`endif
    .JumpTarget   (JumpTarget),
    .BranchOffset (BranchOffset),
    .InstAddress  (InstAddress),
    .running      (running),
    .done         (done),
    .FetchCount   (FetchCount)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic       i, s, h, j, b, c, r;
    logic [7:0] jt, bo;
    logic [7:0] eAddr;
    logic       eRun, eDone;
    logic [3:0] eCnt;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] eAddr;
    logic       eRun, eDone;
    logic [3:0] eCnt;
  } exp_t;

  vec_t table_q[$];
  exp_t sb_q[$];
  int   nApplied = 0;
  int   nMiss    = 0;

  function automatic vec_t mk(logic i, s, h, j, b, c, r, logic [7:0] jt, bo,
                              logic [7:0] ea, logic er, ed, logic [3:0] ec);
    vec_t v;
    v.i = i; v.s = s; v.h = h; v.j = j; v.b = b; v.c = c; v.r = r;
    v.jt = jt; v.bo = bo; v.eAddr = ea; v.eRun = er; v.eDone = ed; v.eCnt = ec;
    return v;
  endfunction

  task automatic check(input int idx, input string name, input int got, input int exp);
    nApplied++;
    if (got != exp) begin
      nMiss++;
      $display("FAIL row%0d %s: got %0h expected %0h", idx, name, got, exp);
    end
  endtask

  // Drive one row at the falling edge, queue its expectation, compare after the edge
  task automatic applyRow(input int idx, input vec_t v);
    exp_t e, got;
    @(negedge CLK);
    init = v.i; start = v.s; halt = v.h; jump_en = v.j; branch_en = v.b;
    call_en = v.c; ret_en = v.r; JumpTarget = v.jt; BranchOffset = v.bo;
    e.idx = idx; e.eAddr = v.eAddr; e.eRun = v.eRun; e.eDone = v.eDone; e.eCnt = v.eCnt;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    got = sb_q.pop_front();
    check(got.idx, "addr", int'(InstAddress), int'(got.eAddr));
    check(got.idx, "running", int'(running), int'(got.eRun));
    check(got.idx, "done", int'(done), int'(got.eDone));
    check(got.idx, "count", int'(FetchCount), int'(got.eCnt));
    $display("row%0d addr=%02h run=%0d done=%0d cnt=%0d", idx, InstAddress, running, done, FetchCount);
  endtask

  initial begin
    init = 1'b1; start = 1'b0; halt = 1'b0; jump_en = 1'b0; branch_en = 1'b0;
    call_en = 1'b0; ret_en = 1'b0; JumpTarget = 8'h00; BranchOffset = 8'h00;

    //                  i  s  h  j  b  c  r  jt     bo     addr  run done cnt
    table_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    table_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    table_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 8'h40, 8'h00, 8'h00, 0, 0, 0)); // ignored in IDLE
    table_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0)); // start
    for (int k = 1; k <= 5; k++)
      table_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'(k), 1, 0, 4'(k)));
    table_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 8'h10, 8'h00, 8'h10, 1, 0, 6));
    table_q.push_back(mk(0, 0, 0, 1, 1, 0, 0, 8'h80, 8'h04, 8'h80, 1, 0, 7)); // jump beats branch
    table_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 8'h02, 8'h00, 8'h02, 1, 0, 8));
    table_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'hFC, 8'hFE, 1, 0, 9)); // backward wrap
    table_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 1, 0, 10));
    table_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 11)); // FF -> 00
    table_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h05, 8'h05, 1, 0, 12));
    table_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 8'hF0, 8'h00, 8'hF0, 1, 0, 13));
    table_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h20, 8'h10, 1, 0, 14)); // forward wrap
    table_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h11, 1, 0, 15));
    table_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h12, 1, 0, 15)); // saturated
    table_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0));  // restart in RUN
    table_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 8'h07, 8'h00, 8'h07, 1, 0, 1));
    table_q.push_back(mk(0, 0, 1, 1, 0, 0, 0, 8'h33, 8'h00, 8'h07, 0, 1, 2));  // halt beats jump
    for (int k = 0; k < 10; k++)
      table_q.push_back(mk(0, 0, k[0], 1, k[1], 0, 0, 8'h33, 8'h09, 8'h07, 0, 1, 2));
    table_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0));  // start from HALTED
    table_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 1, 0, 1));
    table_q.push_back(mk(0, 1, 1, 1, 0, 0, 0, 8'h55, 8'h00, 8'h00, 1, 0, 0));  // start beats all
    table_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 1, 0, 1));
    table_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 8'h66, 8'h00, 8'h00, 0, 0, 0));  // init mid-RUN
`ifdef INST_FETCH_LINK_EN
    table_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0));
    table_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 8'h20, 8'h00, 8'h20, 1, 0, 1));
    table_q.push_back(mk(0, 0, 0, 0, 1, 1, 0, 8'h50, 8'h04, 8'h50, 1, 0, 2));  // call beats branch
    table_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h21, 1, 0, 3));  // return
    table_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'h60, 8'h00, 8'h60, 1, 0, 4));
    table_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'h70, 8'h00, 8'h70, 1, 0, 5));  // nested overwrites
    table_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h61, 1, 0, 6));
    table_q.push_back(mk(0, 0, 0, 1, 0, 1, 1, 8'h3C, 8'h00, 8'h3C, 1, 0, 7));  // jump beats call
    table_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    table_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0));
    table_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 1, 0, 1));  // link was reset
`endif

    // The init-mid-RUN row above needs init raised; patch it in by index
    foreach (table_q[n])
      if (table_q[n].j && table_q[n].jt == 8'h66) table_q[n].i = 1'b1;

    foreach (table_q[n]) applyRow(n, table_q[n]);

    if (sb_q.size() != 0) begin
      nMiss++;
      $display("FAIL scoreboard: got %0d leftover entries expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
    $finish;
  end

endmodule
